wb_write_arbiter: RTL and testbench

- Writeback-side driver of the register-file write port: produces RegWrite/WriteRegister/WriteData, one write per cycle.
- Merges two result sources:
  - single-cycle ALU results, which have priority;
  - long-latency results (load/mul-div) through a valid/ready handshake, buffered in a small FIFO.
- Keeps a pending-destination scoreboard so ID can stall on RAW/WAW hazards against outstanding long-latency ops.

---
 rtl/wb_write_arbiter.sv | 140 ++++++++++++++
 tb/tb_wb_write_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results with buffered long-latency results onto the
// register-file write port, and tracks outstanding long-latency destinations for ID hazard checks.
module wb_write_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs1_q,
  input  logic [4:0]  rs2_q,
  input  logic [4:0]  rd_q,
  output logic        pend_rs1,
  output logic        pend_rs2,
  output logic        pend_rd,
  output logic        RegWrite,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] DepthCnt  = CntW'(FIFO_DEPTH);
  localparam logic [StW-1:0]  StarveMax = StW'(STARVE_LIMIT);

  logic [4:0]      fifo_rd_q   [FIFO_DEPTH];
  logic [31:0]     fifo_data_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic [StW-1:0]  starve_q, starve_d;
  logic [31:0]     pending_q, pending_d;

  logic        fifo_nonempty;
  logic        push;
  logic        pop;
  logic        alu_win;
  logic [4:0]  head_rd;
  logic [31:0] head_data;

  assign fifo_nonempty = (count_q != '0);
  assign mem_ready     = (count_q < DepthCnt);
  assign alu_stall     = (starve_q == StarveMax) && fifo_nonempty;
  assign alu_win       = alu_valid && (alu_rd != 5'd0) && !alu_stall;
  assign pop           = fifo_nonempty && !alu_win;
  // Writes to x0 complete the handshake but never occupy a slot.
  assign push          = mem_valid && mem_ready && (mem_rd != 5'd0);
  assign head_rd       = fifo_rd_q[rd_ptr_q];
  assign head_data     = fifo_data_q[rd_ptr_q];

  assign pend_rs1 = (rs1_q != 5'd0) && pending_q[rs1_q];
  assign pend_rs2 = (rs2_q != 5'd0) && pending_q[rs2_q];
  assign pend_rd  = (rd_q  != 5'd0) && pending_q[rd_q];

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (pop || !fifo_nonempty) begin
      starve_d = '0;
    end else if (alu_win && (starve_q != StarveMax)) begin
      starve_d = starve_q + StW'(1);
    end
  end

  // A new issue to the same rd as the retiring entry must stay pending, so set is applied last.
  always_comb begin
    pending_d = pending_q;
    if (pop) begin
      pending_d[head_rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != 5'd0)) begin
      pending_d[issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Storage needs no reset: entries are only read while count_q says they are valid.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= mem_rd;
      fifo_data_q[wr_ptr_q] <= mem_data;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      pending_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q   <= count_d;
      starve_q  <= starve_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      RegWrite      <= 1'b0;
      WriteRegister <= 5'd0;
      WriteData     <= 32'd0;
    end else if (alu_win) begin
      RegWrite      <= 1'b1;
      WriteRegister <= alu_rd;
      WriteData     <= alu_data;
    end else if (pop) begin
      RegWrite      <= 1'b1;
      WriteRegister <= head_rd;
      WriteData     <= head_data;
    end else begin
      RegWrite      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed self-checking bench for wb_write_arbiter (FIFO_DEPTH=2, STARVE_LIMIT=4).
module tb_wb_write_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_q, rs2_q, rd_q;
  logic        pend_rs1, pend_rs2, pend_rd;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;

  int n_checks = 0;
  int n_fail   = 0;

  wb_write_arbiter #(
    .FIFO_DEPTH  (2),
    .STARVE_LIMIT(4)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .alu_stall    (alu_stall),
    .mem_valid    (mem_valid),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .rs1_q        (rs1_q),
    .rs2_q        (rs2_q),
    .rd_q         (rd_q),
    .pend_rs1     (pend_rs1),
    .pend_rs2     (pend_rs2),
    .pend_rd      (pend_rd),
    .RegWrite     (RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData    (WriteData)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid   = 1'b0;
    alu_rd      = 5'd0;
    alu_data    = 32'd0;
    mem_valid   = 1'b0;
    mem_rd      = 5'd0;
    mem_data    = 32'd0;
    issue_valid = 1'b0;
    issue_rd    = 5'd0;
    rs1_q       = 5'd0;
    rs2_q       = 5'd0;
    rd_q        = 5'd0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    sys_rst = 1'b1;
    #3;
    n_checks++;
    if ({RegWrite, WriteRegister, WriteData} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_wb: got we=%0b rd=%0d data=%h, want 0/0/0", RegWrite, WriteRegister,
               WriteData);
    end
    n_checks++;
    if ({alu_stall, mem_ready, pend_rs1, pend_rs2, pend_rd} !== 5'b01000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got stall/ready/p1/p2/pd=%b, want 01000",
               {alu_stall, mem_ready, pend_rs1, pend_rs2, pend_rd});
    end
    tick();
    sys_rst = 1'b0;
  endtask

  task automatic test_alu_write();
    reset_dut();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    tick();
    n_checks++;
    if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd5, 32'h1234}) begin
      n_fail++;
      $display("FAIL alu_write: got we=%0b rd=%0d data=%h, want 1/5/00001234", RegWrite,
               WriteRegister, WriteData);
    end
    alu_rd = 5'd0; alu_data = 32'hFFFF;
    tick();
    n_checks++;
    if ({RegWrite, WriteRegister, WriteData, alu_stall} !== {1'b0, 5'd5, 32'h1234, 1'b0}) begin
      n_fail++;
      $display("FAIL alu_x0_drop: got we=%0b rd=%0d data=%h stall=%0b, want 0/5/00001234/0",
               RegWrite, WriteRegister, WriteData, alu_stall);
    end
  endtask

  task automatic test_long_latency();
    reset_dut();
    rd_q = 5'd7; issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    n_checks++;
    if (pend_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_no_bypass: got %0b, want 0", pend_rd);
    end
    tick();
    issue_valid = 1'b0;
    n_checks++;
    if (pend_rd !== 1'b1) begin
      n_fail++;
      $display("FAIL pend_after_issue: got %0b, want 1", pend_rd);
    end
    tick();
    tick();
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'hDEADBEEF;
    tick();
    mem_valid = 1'b0;
    n_checks++;
    if ({RegWrite, pend_rd} !== 2'b01) begin
      n_fail++;
      $display("FAIL ll_accept_cycle: got we=%0b pend=%0b, want 0/1", RegWrite, pend_rd);
    end
    tick();
    n_checks++;
    if ({RegWrite, WriteRegister, WriteData, pend_rd} !== {1'b1, 5'd7, 32'hDEADBEEF, 1'b0}) begin
      n_fail++;
      $display("FAIL ll_write: got we=%0b rd=%0d data=%h pend=%0b, want 1/7/deadbeef/0",
               RegWrite, WriteRegister, WriteData, pend_rd);
    end
    tick();
    n_checks++;
    if ({RegWrite, pend_rd} !== 2'b00) begin
      n_fail++;
      $display("FAIL ll_after_write: got we=%0b pend=%0b, want 0/0", RegWrite, pend_rd);
    end
  endtask

  task automatic test_fifo_full();
    reset_dut();
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'hA0;
    mem_valid = 1'b1; mem_rd = 5'd11; mem_data = 32'hB11;
    tick();
    n_checks++;
    if ({mem_ready, RegWrite, WriteRegister} !== {1'b1, 1'b1, 5'd20}) begin
      n_fail++;
      $display("FAIL full_push1: got ready=%0b we=%0b rd=%0d, want 1/1/20", mem_ready, RegWrite,
               WriteRegister);
    end
    mem_rd = 5'd12; mem_data = 32'hB12;
    tick();
    n_checks++;
    if (mem_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_push2: got ready=%0b, want 0", mem_ready);
    end
    mem_rd = 5'd13; mem_data = 32'hB13;
    tick();
    tick();
    tick();
    n_checks++;
    if ({mem_ready, alu_stall, RegWrite, WriteRegister} !== {1'b0, 1'b1, 1'b1, 5'd20}) begin
      n_fail++;
      $display("FAIL full_held: got ready=%0b stall=%0b we=%0b rd=%0d, want 0/1/1/20", mem_ready,
               alu_stall, RegWrite, WriteRegister);
    end
    tick();
    n_checks++;
    if ({RegWrite, WriteRegister, WriteData, mem_ready, alu_stall} !==
        {1'b1, 5'd11, 32'hB11, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL full_pop1: got we=%0b rd=%0d data=%h ready=%0b stall=%0b, want 1/11/b11/1/0",
               RegWrite, WriteRegister, WriteData, mem_ready, alu_stall);
    end
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    n_checks++;
    if ({RegWrite, WriteRegister, mem_ready} !== {1'b1, 5'd20, 1'b0}) begin
      n_fail++;
      $display("FAIL full_push3: got we=%0b rd=%0d ready=%0b, want 1/20/0", RegWrite,
               WriteRegister, mem_ready);
    end
    tick();
    n_checks++;
    if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd12, 32'hB12}) begin
      n_fail++;
      $display("FAIL full_order2: got we=%0b rd=%0d data=%h, want 1/12/b12", RegWrite,
               WriteRegister, WriteData);
    end
    tick();
    n_checks++;
    if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd13, 32'hB13}) begin
      n_fail++;
      $display("FAIL full_order3: got we=%0b rd=%0d data=%h, want 1/13/b13", RegWrite,
               WriteRegister, WriteData);
    end
    tick();
    n_checks++;
    if ({RegWrite, mem_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL full_drained: got we=%0b ready=%0b, want 0/1", RegWrite, mem_ready);
    end
  endtask

  task automatic test_starvation();
    reset_dut();
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h33;
    tick();
    mem_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({RegWrite, WriteRegister, WriteData, alu_stall} !==
          {1'b1, 5'd4, 32'h44, (i == 3)}) begin
        n_fail++;
        $display("FAIL starve_alu%0d: got we=%0b rd=%0d data=%h stall=%0b, want 1/4/44/%0b", i,
                 RegWrite, WriteRegister, WriteData, alu_stall, (i == 3));
      end
    end
    tick();
    n_checks++;
    if ({RegWrite, WriteRegister, WriteData, alu_stall} !== {1'b1, 5'd3, 32'h33, 1'b0}) begin
      n_fail++;
      $display("FAIL starve_pop: got we=%0b rd=%0d data=%h stall=%0b, want 1/3/33/0", RegWrite,
               WriteRegister, WriteData, alu_stall);
    end
    tick();
    alu_valid = 1'b0;
    n_checks++;
    if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd4, 32'h44}) begin
      n_fail++;
      $display("FAIL starve_held_alu: got we=%0b rd=%0d data=%h, want 1/4/44", RegWrite,
               WriteRegister, WriteData);
    end
  endtask

  task automatic test_set_wins_and_x0();
    reset_dut();
    rs1_q = 5'd9; rs2_q = 5'd0; rd_q = 5'd9;
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
    tick();
    mem_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0;
    n_checks++;
    if ({RegWrite, WriteRegister, WriteData, pend_rd} !== {1'b1, 5'd9, 32'h99, 1'b1}) begin
      n_fail++;
      $display("FAIL set_wins: got we=%0b rd=%0d data=%h pend=%0b, want 1/9/99/1", RegWrite,
               WriteRegister, WriteData, pend_rd);
    end
    n_checks++;
    if ({pend_rs1, pend_rs2} !== 2'b10) begin
      n_fail++;
      $display("FAIL pend_rs: got rs1=%0b rs2=%0b, want 1/0", pend_rs1, pend_rs2);
    end
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h55;
    #1;
    n_checks++;
    if (mem_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL x0_ready: got %0b, want 1", mem_ready);
    end
    tick();
    mem_valid = 1'b0;
    tick();
    n_checks++;
    if ({RegWrite, WriteRegister, WriteData, mem_ready, pend_rd} !==
        {1'b0, 5'd9, 32'h99, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL x0_discard: got we=%0b rd=%0d data=%h ready=%0b pend=%0b, want 0/9/99/1/1",
               RegWrite, WriteRegister, WriteData, mem_ready, pend_rd);
    end
  endtask

  task automatic test_reset_midop();
    reset_dut();
    issue_valid = 1'b1; issue_rd = 5'd14;
    tick();
    issue_rd = 5'd15;
    tick();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'hA0;
    mem_valid = 1'b1; mem_rd = 5'd14; mem_data = 32'hE14;
    tick();
    mem_rd = 5'd15; mem_data = 32'hE15;
    tick();
    rs1_q = 5'd14; rs2_q = 5'd15; rd_q = 5'd14;
    #1;
    n_checks++;
    if ({pend_rs1, pend_rs2, pend_rd, mem_ready} !== 4'b1110) begin
      n_fail++;
      $display("FAIL midop_before: got p1/p2/pd/ready=%b, want 1110",
               {pend_rs1, pend_rs2, pend_rd, mem_ready});
    end
    #1;
    sys_rst = 1'b1;
    #1;
    n_checks++;
    if ({RegWrite, WriteRegister, WriteData, pend_rs1, pend_rs2, pend_rd, mem_ready, alu_stall}
        !== {1'b0, 5'd0, 32'd0, 5'b00010}) begin
      n_fail++;
      $display("FAIL midop_reset: got we=%0b rd=%0d data=%h p1/p2/pd/ready/stall=%b",
               RegWrite, WriteRegister, WriteData,
               {pend_rs1, pend_rs2, pend_rd, mem_ready, alu_stall});
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    tick();
    sys_rst = 1'b0;
    tick();
    n_checks++;
    if ({RegWrite, mem_ready, pend_rs1, pend_rs2} !== 4'b0100) begin
      n_fail++;
      $display("FAIL midop_release1: got we/ready/p1/p2=%b, want 0100",
               {RegWrite, mem_ready, pend_rs1, pend_rs2});
    end
    tick();
    n_checks++;
    if ({RegWrite, WriteRegister, WriteData} !== 38'd0) begin
      n_fail++;
      $display("FAIL midop_no_stale: got we=%0b rd=%0d data=%h, want 0/0/0", RegWrite,
               WriteRegister, WriteData);
    end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_long_latency();
    test_fifo_full();
    test_starvation();
    test_set_wins_and_x0();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
